// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch: reads one byte per request,
// assembles the instruction and hands decoded fields to decode.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic [1:0]  stat,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_ISSUE, S_WAIT, S_PRESENT, S_HALTED, S_STOP, S_DRAIN
  } state_t;

  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  state_t      state, state_n;
  logic [63:0] pc;
  logic [3:0]  idx;
  logic [3:0]  cur_len;
  logic [3:0]  vpos;
  logic        last;
  logic [63:0] len64;

  // Length 0 marks an invalid icode.
  function automatic logic [3:0] ilen(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h9:        ilen = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  ilen = 4'd2;
      4'h7, 4'h8:              ilen = 4'd9;
      4'h3, 4'h4, 4'h5:        ilen = 4'd10;
      default:                 ilen = 4'd0;
    endcase
  endfunction

  assign cur_len = (idx == 4'd0) ? ilen(mem_rdata[7:4]) : ilen(icode);
  assign last    = (idx + 4'd1) == cur_len;
  assign len64   = {60'd0, cur_len};
  assign vpos    = (cur_len == 4'd10) ? idx - 4'd2 : idx - 4'd1;

  assign mem_addr    = pc + {60'd0, idx};
  assign mem_rd      = (state == S_ISSUE) && !redirect_valid && !rst;
  assign instr_valid = (state == S_PRESENT);
  assign busy        = (state == S_ISSUE) || (state == S_WAIT) ||
                       (state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ISSUE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (redirect_valid) begin
      if ((state == S_WAIT || state == S_DRAIN) && !mem_rvalid)
        state_n = S_DRAIN;
      else
        state_n = S_ISSUE;
    end else begin
      unique case (state)
        S_ISSUE: state_n = S_WAIT;
        S_WAIT: begin
          if (mem_rvalid) begin
            if (mem_err || cur_len == 4'd0 || last) state_n = S_PRESENT;
            else                                    state_n = S_ISSUE;
          end
        end
        S_PRESENT: begin
          if (instr_ready) begin
            if (stat != AOK)         state_n = S_STOP;
            else if (icode == 4'h0)  state_n = S_HALTED;
            else                     state_n = S_ISSUE;
          end
        end
        S_DRAIN: if (mem_rvalid) state_n = S_ISSUE;
        S_HALTED, S_STOP: state_n = state;
        default: state_n = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      idx    <= 4'd0;
      icode  <= 4'h0;
      ifun   <= 4'h0;
      rA     <= 4'hF;
      rB     <= 4'hF;
      valC   <= 64'd0;
      valP   <= 64'd0;
      pc_out <= 64'd0;
      stat   <= AOK;
    end else if (redirect_valid) begin
      pc   <= redirect_pc;
      idx  <= 4'd0;
      stat <= AOK;
    end else if (state == S_WAIT && mem_rvalid) begin
      pc_out <= pc;
      if (mem_err) begin
        stat <= ADR;
        valP <= pc;
        if (idx == 4'd0) begin
          icode <= 4'h0;
          ifun  <= 4'h0;
          rA    <= 4'hF;
          rB    <= 4'hF;
          valC  <= 64'd0;
        end
      end else if (idx == 4'd0) begin
        // Byte 0 clears every field so nothing from the last instruction leaks.
        icode <= mem_rdata[7:4];
        ifun  <= mem_rdata[3:0];
        rA    <= 4'hF;
        rB    <= 4'hF;
        valC  <= 64'd0;
        if (cur_len == 4'd0) begin
          stat <= INS;
          valP <= pc;
        end else if (last) begin
          valP <= pc + len64;
        end else begin
          idx <= idx + 4'd1;
        end
      end else begin
        if (idx == 4'd1 && (cur_len == 4'd2 || cur_len == 4'd10))
          {rA, rB} <= mem_rdata;
        else
          valC[{vpos[2:0], 3'b000} +: 8] <= mem_rdata;
        if (last) valP <= pc + len64;
        else      idx  <= idx + 4'd1;
      end
    end else if (state == S_PRESENT && instr_ready) begin
      if (stat == AOK && icode != 4'h0) begin
        pc  <= valP;
        idx <= 4'd0;
      end else if (stat == AOK) begin
        stat <= HLT;
      end
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Byte-serial instruction fetch controller for the Y86-64 core.
- Reads a single-port, byte-wide instruction memory one byte per request, assembles a full instruction (1–10 bytes), and presents the decoded fields (icode, ifun, rA, rB, valC, valP) to decode with a valid/ready handshake.
- Sequences the PC: sequential valP advance, redirect from later stages (jumps, call, ret), and halt, invalid-instruction and address-error stops.

Parameters:
RESET_PC, 64'd0, PC loaded on reset.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
mem_rd  out  1  one-cycle read request pulse
mem_addr  out  64  byte address, valid while mem_rd=1
mem_rdata  in  8  returned byte, valid when mem_rvalid=1
mem_rvalid  in  1  read data valid, exactly one per mem_rd, >=1 cycle after it
mem_err  in  1  address error, sampled with mem_rvalid
redirect_valid  in  1  load new PC, squash current fetch
redirect_pc  in  64  target PC
instr_valid  out  1  fetched instruction available
instr_ready  in  1  decode accepts instruction
icode  out  4  byte0[7:4]
ifun  out  4  byte0[3:0]
rA  out  4  byte1[7:4], else 4'hF
rB  out  4  byte1[3:0], else 4'hF
valC  out  64  little-endian constant, else 0
valP  out  64  pc_out + length, mod 2^64
pc_out  out  64  address of presented instruction
stat  out  2  0=AOK 1=HLT 2=ADR 3=INS
busy  out  1  high in ISSUE, WAIT, DRAIN

Behaviour:
- Reset (async): state ISSUE, pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, instr_valid=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, pc_out=0, stat=AOK. First mem_rd is issued in the first cycle after rst deasserts.
- Length by icode:
  - 0, 1, 9 -> 1
  - 2, 6, A, B -> 2
  - 7, 8 -> 9; valC = bytes 1..8
  - 3, 4, 5 -> 10; rA/rB = byte1, valC = bytes 2..9
  - other -> INS
- Byte k (k=0..len-1) is read from pc+k, wrapping mod 2^64.
- States:
  - ISSUE: mem_rd=1, mem_addr=pc+idx; next WAIT.
  - WAIT: mem_rd=0; hold until mem_rvalid.
    - mem_err=1 -> stat=ADR, go PRESENT.
    - idx=0 with invalid icode -> stat=INS, go PRESENT.
    - otherwise store byte; if idx+1 = len go PRESENT, else idx+1 and go ISSUE.
  - PRESENT: instr_valid=1. All outputs stable until instr_valid && instr_ready.
    - On handshake: stat AOK -> pc=valP, idx=0, go ISSUE. icode 0 -> go HALTED with stat=HLT. ADR/INS -> go STOP.
  - HALTED / STOP: no reads, instr_valid=0, stat held.
  - DRAIN: a read is outstanding at redirect; wait for mem_rvalid, discard the byte, then go ISSUE at the saved redirect pc.
- Latency: each byte costs 2 cycles with 1-cycle memory, so a 2-byte instruction reaches instr_valid at cycle 4 after the first mem_rd.
- Redirect has highest priority in every state, including HALTED and STOP:
  - pc=redirect_pc, idx=0, stat=AOK, instr_valid=0 next cycle.
  - From WAIT without mem_rvalid in the same cycle, go DRAIN; otherwise go ISSUE.
  - Same cycle as an accepting handshake: the instruction counts as delivered and the next PC is redirect_pc, not valP.
  - Redirect during DRAIN: latest redirect_pc wins.
- At most one outstanding read at any time. mem_rd is never asserted in WAIT, DRAIN, PRESENT, HALTED or STOP.
- Unused fields for short instructions are forced to defaults (rA=rB=F, valC=0); stale bytes never leak.
- ADR/INS present: icode/ifun reflect byte0 if it was read, else 0; valP = pc_out.

Test Plan:
- Memory [30 F3 0A 00 00 00 00 00 00 00] at 0, ready=1, 1-cycle memory -> 10 reads at addr 0..9, then icode=3 ifun=0 rA=F rB=3 valC=64'h0A valP=10 stat=AOK, next mem_addr=10.
- Sequence 10, 60 23, 00 at 0 -> nop(valP=1), OPq rA=2 rB=3 (valP=3), halt; then stat=HLT, no further mem_rd after halt is accepted.
- instr_ready held 0 for 5 cycles on the OPq -> outputs stable for all 5 cycles, no mem_rd; fetch resumes the cycle after ready=1.
- redirect_valid=1 with redirect_pc=64'h40 while a byte read at addr 3 is outstanding and mem_rvalid is delayed 3 cycles -> DRAIN; the returning byte is discarded, the next mem_rd is at 0x40, busy=1 throughout.
- Byte F0 at 0 -> instr_valid with stat=INS after 1 read, then STOP. A redirect to 0x10 restarts fetch with stat=AOK.
- mem_err=1 on byte 2 of rmmovq -> stat=ADR, valP=pc_out. rst asserted mid-WAIT -> immediate reset values, fetch restarts at RESET_PC.
